// File: rtl/arith_seq_addsub.sv
// arith_seq_addsub: multi-cycle add/subtract unit, CHUNK bits per cycle,
// LSB chunk first, with a registered carry between chunks.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   operands valid            in_ready   unit can accept operands
//   a, b       operands (WIDTH)          ctrl       0 = a+b, 1 = a-b
//   out_valid  result valid              out_ready  consumer accepts result
//   z          result (WIDTH)
//   cout       carry out of MSB (subtract: 1 = no borrow)
//   ovf        signed overflow           zero       z == 0
//   neg        z[WIDTH-1]
//
// Optional feature: define ARITH_SAT_EN to clamp z to the signed extreme on
// overflow. Without it z wraps modulo 2^WIDTH.
module arith_seq_addsub #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int unsigned N  = WIDTH / CHUNK;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  // Reject configurations where the operand does not split into whole chunks.
  if (CHUNK == 0 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("arith_seq_addsub: WIDTH must be a non-zero multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, z_q, z_d;
  logic            carry_q, carry_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d, neg_q, neg_d;
  logic            in_ready_q, in_ready_d, out_valid_q, out_valid_d;

  logic [CHUNK:0]   sum;
  logic [WIDTH-1:0] z_shift;
  logic [WIDTH-1:0] z_fin;
  logic             ovf_raw;

  // Registers: FSM state, operand shifters, carry, counter, result and flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      z_q         <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      z_q         <= z_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state and datapath. Operands shift right each cycle so the active
  // chunk is always the low CHUNK bits; result chunks enter z from the top,
  // so after N cycles z holds the full sum in order and the low chunk of the
  // operand registers holds the original MSB chunk.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    z_d         = z_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    neg_d       = neg_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    sum     = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + (CHUNK+1)'(carry_q);
    z_shift = (z_q >> CHUNK) | (WIDTH'(sum[CHUNK-1:0]) << (WIDTH - CHUNK));
    ovf_raw = (a_q[CHUNK-1] == b_q[CHUNK-1]) && (sum[CHUNK-1] != a_q[CHUNK-1]);
    z_fin   = z_shift;
`ifdef ARITH_SAT_EN
    // Clamp towards the sign of A; flags below still see the raw carry/ovf.
    if (ovf_raw) begin
      z_fin = a_q[CHUNK-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d        = a;
          b_d        = ctrl ? ~b : b;
          carry_d    = ctrl;
          cnt_d      = '0;
          state_d    = BUSY;
          in_ready_d = 1'b0;
        end
      end
      BUSY: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        carry_d = sum[CHUNK];
        z_d     = z_shift;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          z_d         = z_fin;
          cout_d      = sum[CHUNK];
          ovf_d       = ovf_raw;
          zero_d      = (z_fin == '0);
          neg_d       = z_fin[WIDTH-1];
          cnt_d       = '0;
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign z         = z_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign neg       = neg_q;

endmodule

// File: tb/tb_arith_seq_addsub.sv
// Directed testbench for arith_seq_addsub: WIDTH=32/CHUNK=8 (main instance),
// WIDTH=32/CHUNK=32 and WIDTH=16/CHUNK=4. Expected values are hand-computed.
module tb_arith_seq_addsub;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        iv0, ir0, c0, ov0, or0, co0, of0, ze0, ng0;
  logic [31:0] a0, b0, z0;
  logic        iv1, ir1, c1, ov1, or1, co1, of1, ze1, ng1;
  logic [31:0] a1, b1, z1;
  logic        iv2, ir2, c2, ov2, or2, co2, of2, ze2, ng2;
  logic [15:0] a2, b2, z2;

  int checks = 0;
  int passed = 0;

  arith_seq_addsub #(.WIDTH(32), .CHUNK(8)) dut0 (
    .clk(clk), .reset(reset), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0),
    .ctrl(c0), .out_valid(ov0), .out_ready(or0), .z(z0), .cout(co0), .ovf(of0),
    .zero(ze0), .neg(ng0));

  arith_seq_addsub #(.WIDTH(32), .CHUNK(32)) dut1 (
    .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
    .ctrl(c1), .out_valid(ov1), .out_ready(or1), .z(z1), .cout(co1), .ovf(of1),
    .zero(ze1), .neg(ng1));

  arith_seq_addsub #(.WIDTH(16), .CHUNK(4)) dut2 (
    .clk(clk), .reset(reset), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
    .ctrl(c2), .out_valid(ov2), .out_ready(or2), .z(z2), .cout(co2), .ovf(of2),
    .zero(ze2), .neg(ng2));

  // Drive one operation into dut0 at the current negedge; return the number
  // of rising edges from the accepting edge until out_valid, or 99 on timeout.
  task automatic run0(input logic [31:0] a, input logic [31:0] b, input logic c,
                      output int lat);
    a0 = a; b0 = b; c0 = c; iv0 = 1'b1;
    @(negedge clk);
    iv0 = 1'b0; a0 = 32'hDEAD_BEEF; b0 = 32'hCAFE_F00D; c0 = ~c;
    lat = 0;
    while (ov0 !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (ov0 !== 1'b1) lat = 99;
  endtask

  task automatic pop0();
    or0 = 1'b1;
    @(negedge clk);
    or0 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({ir0, ov0, z0, co0, of0, ze0, ng0} !== {1'b1, 1'b0, 32'd0, 4'b0000})
      $display("FAIL reset_dut0 got ir=%b ov=%b z=%h flags=%b%b%b%b want ir=1 ov=0 z=0 flags=0000",
               ir0, ov0, z0, co0, of0, ze0, ng0);
    else passed++;
    checks++;
    if ({ir1, ov1, z1, co1, of1, ze1, ng1, ir2, ov2, z2, co2, of2, ze2, ng2} !==
        {1'b1, 1'b0, 32'd0, 4'b0000, 1'b1, 1'b0, 16'd0, 4'b0000})
      $display("FAIL reset_dut12 got ir1=%b ov1=%b z1=%h ir2=%b ov2=%b z2=%h want 1 0 0 1 0 0",
               ir1, ov1, z1, ir2, ov2, z2);
    else passed++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add();
    int lat;
    run0(32'd5, 32'd3, 1'b0, lat);
    checks++;
    if (lat !== 4) $display("FAIL add_latency got %0d want 4", lat);
    else passed++;
    checks++;
    if ({z0, co0, of0, ze0, ng0} !== {32'd8, 4'b0000})
      $display("FAIL add_5_3 got z=%h c=%b o=%b z=%b n=%b want z=8 flags=0000",
               z0, co0, of0, ze0, ng0);
    else passed++;
    pop0();
  endtask

  task automatic test_sub();
    logic [31:0] ta [3];
    logic [31:0] tb [3];
    logic [35:0] te [3];
    int lat;
    ta = '{32'd5, 32'd3, 32'd7};
    tb = '{32'd3, 32'd5, 32'd7};
    te = '{{32'd2, 4'b1000}, {32'hFFFF_FFFE, 4'b0001}, {32'd0, 4'b1010}};
    for (int i = 0; i < 3; i++) begin
      run0(ta[i], tb[i], 1'b1, lat);
      checks++;
      if ({z0, co0, of0, ze0, ng0} !== te[i] || lat !== 4)
        $display("FAIL sub_%0d got z=%h flags=%b%b%b%b lat=%0d want z=%h flags=%b lat=4",
                 i, z0, co0, of0, ze0, ng0, lat, te[i][35:4], te[i][3:0]);
      else passed++;
      pop0();
    end
  endtask

  task automatic test_overflow();
    int lat;
    logic [35:0] exp_sat;
`ifdef ARITH_SAT_EN
    exp_sat = {32'h7FFF_FFFF, 4'b0100};
`else
    exp_sat = {32'h8000_0000, 4'b0101};
`endif
    run0(32'h7FFF_FFFF, 32'd1, 1'b0, lat);
    checks++;
    if ({z0, co0, of0, ze0, ng0} !== exp_sat)
      $display("FAIL ovf_pos got z=%h flags=%b%b%b%b want z=%h flags=%b",
               z0, co0, of0, ze0, ng0, exp_sat[35:4], exp_sat[3:0]);
    else passed++;
    pop0();
    checks++;
    if (ir0 !== 1'b1) $display("FAIL ready_after_pop got %b want 1", ir0);
    else passed++;
    run0(32'hFFFF_FFFF, 32'd1, 1'b0, lat);
    checks++;
    if ({z0, co0, of0, ze0, ng0} !== {32'd0, 4'b1010})
      $display("FAIL wrap_zero got z=%h flags=%b%b%b%b want z=0 flags=1010",
               z0, co0, of0, ze0, ng0);
    else passed++;
    pop0();
  endtask

  task automatic test_backpressure();
    int lat;
    run0(32'h10, 32'h20, 1'b0, lat);
    for (int i = 0; i < 5; i++) begin
      iv0 = 1'b1; a0 = $urandom; b0 = $urandom; c0 = 1'b1;
      @(negedge clk);
      checks++;
      if ({ov0, ir0, z0, co0, of0, ze0, ng0} !== {1'b1, 1'b0, 32'h30, 4'b0000})
        $display("FAIL hold_%0d got ov=%b ir=%b z=%h flags=%b%b%b%b want ov=1 ir=0 z=30 flags=0000",
                 i, ov0, ir0, z0, co0, of0, ze0, ng0);
      else passed++;
    end
    iv0 = 1'b0;
    pop0();
    checks++;
    if ({ov0, ir0} !== 2'b01) $display("FAIL release got ov=%b ir=%b want ov=0 ir=1", ov0, ir0);
    else passed++;
    @(negedge clk);
    checks++;
    if ({ov0, ir0} !== 2'b01) $display("FAIL no_accept got ov=%b ir=%b want ov=0 ir=1", ov0, ir0);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int lat;
    a0 = 32'h1122_3344; b0 = 32'h1111_1111; c0 = 1'b0; iv0 = 1'b1;
    @(negedge clk);
    iv0 = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({ov0, ir0, z0} !== {1'b0, 1'b1, 32'd0})
      $display("FAIL async_reset got ov=%b ir=%b z=%h want ov=0 ir=1 z=0", ov0, ir0, z0);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    run0(32'd1, 32'd1, 1'b0, lat);
    checks++;
    if ({z0, co0, of0, ze0, ng0} !== {32'd2, 4'b0000} || lat !== 4)
      $display("FAIL after_abort got z=%h flags=%b%b%b%b lat=%0d want z=2 flags=0000 lat=4",
               z0, co0, of0, ze0, ng0, lat);
    else passed++;
    pop0();
  endtask

  task automatic test_full_chunk();
    int lat;
    a1 = 32'h1234_5678; b1 = 32'h1111_1111; c1 = 1'b0; iv1 = 1'b1;
    @(negedge clk);
    iv1 = 1'b0;
    lat = 0;
    while (ov1 !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if ({z1, co1, of1, ze1, ng1} !== {32'h2345_6789, 4'b0000} || lat !== 1)
      $display("FAIL full_chunk got z=%h flags=%b%b%b%b lat=%0d want z=23456789 flags=0000 lat=1",
               z1, co1, of1, ze1, ng1, lat);
    else passed++;
    or1 = 1'b1;
    @(negedge clk);
    or1 = 1'b0;
  endtask

  task automatic test_narrow();
    int lat;
    a2 = 16'h00FF; b2 = 16'h0001; c2 = 1'b0; iv2 = 1'b1;
    @(negedge clk);
    iv2 = 1'b0;
    lat = 0;
    while (ov2 !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if ({z2, co2, of2, ze2, ng2} !== {16'h0100, 4'b0000} || lat !== 4)
      $display("FAIL narrow got z=%h flags=%b%b%b%b lat=%0d want z=0100 flags=0000 lat=4",
               z2, co2, of2, ze2, ng2, lat);
    else passed++;
    or2 = 1'b1;
    @(negedge clk);
    or2 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    iv0 = 1'b0; a0 = '0; b0 = '0; c0 = 1'b0; or0 = 1'b0;
    iv1 = 1'b0; a1 = '0; b1 = '0; c1 = 1'b0; or1 = 1'b0;
    iv2 = 1'b0; a2 = '0; b2 = '0; c2 = 1'b0; or2 = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_full_chunk();
    test_narrow();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
